reg_scan_arbiter: RTL and testbench

REG_SCAN_ARBITER -- requirements
Module: reg_scan_arbiter

---
 rtl/reg_scan_arbiter_pkg.sv | 13 +
 rtl/reg_scan_arbiter_scan_out_reg.sv | 34 +++
 rtl/reg_scan_arbiter.sv | 108 ++++++++++
 tb/tb_reg_scan_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scan_arbiter_pkg.sv
// Shared definitions for the register-file scan arbiter: FSM encoding and index width.
package reg_scan_arbiter_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } scan_state_t;

endpackage

// File: rtl/reg_scan_arbiter_scan_out_reg.sv
// Valid/ready holding register for the dump stream: loads one beat, holds it
// stable until the consumer accepts it.
module scan_out_reg #(
   parameter int IDX_W  = 5,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [IDX_W-1:0]  load_index,
   input  logic [DATA_W-1:0] load_data,
   input  logic              ready,
   output logic              valid,
   output logic [IDX_W-1:0]  index,
   output logic [DATA_W-1:0] data
);

   // A beat transfers on any rising edge where valid and ready are both high;
   // index/data change only on load, so they stay stable while ready is low.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         index <= '0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         index <= load_index;
         data  <= load_data;
      end else if (valid && ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/reg_scan_arbiter.sv
// Steals regfile read port A from the processor to dump every register onto a
// valid/ready stream, forcing the steal after STARVE_MAX denied cycles.
module reg_scan_arbiter
   import reg_scan_arbiter_pkg::*;
#(
   parameter int NUM_REGS   = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 15
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic [REG_IDX_W-1:0] cpu_readRegA,
   output logic                 cpu_stall,
   output logic [REG_IDX_W-1:0] ctrl_readRegA,
   input  logic [DATA_W-1:0]    data_readRegA,
   input  logic                 scan_start,
   output logic                 scan_busy,
   output logic                 scan_done,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [REG_IDX_W-1:0] out_reg,
   output logic [DATA_W-1:0]    out_data,
   output logic [1:0]           state_dbg
);

   localparam int STARVE_W = $clog2(STARVE_MAX + 1);
   localparam logic [REG_IDX_W-1:0] LAST_IDX   = REG_IDX_W'(NUM_REGS - 1);
   localparam logic [STARVE_W-1:0]  STARVE_LIM = STARVE_W'(STARVE_MAX);

   scan_state_t           state, state_next;
   logic [REG_IDX_W-1:0]  idx, idx_next;
   logic [STARVE_W-1:0]   starve, starve_next;
   logic                  grant;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         starve <= '0;
      end else begin
         state  <= state_next;
         idx    <= idx_next;
         starve <= starve_next;
      end
   end

   always_comb begin
      state_next    = state;
      idx_next      = idx;
      starve_next   = starve;
      grant         = 1'b0;
      cpu_stall     = 1'b0;
      ctrl_readRegA = cpu_readRegA;
      case (state)
         IDLE: begin
            if (scan_start) begin
               state_next = READ;
               idx_next   = '0;
            end
         end
         READ: begin
            // The scan takes the port when the processor is quiet, or by force once starved.
            grant = !cpu_req || (starve == STARVE_LIM);
            if (grant) begin
               cpu_stall     = cpu_req;
               ctrl_readRegA = idx;
               starve_next   = '0;
               state_next    = HOLD;
            end else if (starve != STARVE_LIM) begin
               starve_next = starve + 1'b1;
            end
         end
         HOLD: begin
            if (out_valid && out_ready) begin
               if (idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx + 1'b1;
                  state_next = READ;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign scan_busy = (state == READ) || (state == HOLD);
   assign scan_done = (state == DONE);
   assign state_dbg = state;

   scan_out_reg #(
      .IDX_W  (REG_IDX_W),
      .DATA_W (DATA_W)
   ) u_out (
      .clock      (clock),
      .reset      (reset),
      .load       (grant),
      .load_index (idx),
      .load_data  (data_readRegA),
      .ready      (out_ready),
      .valid      (out_valid),
      .index      (out_reg),
      .data       (out_data)
   );

endmodule

// File: tb/tb_reg_scan_arbiter.sv
// Bench for reg_scan_arbiter: scoreboard of expected dump beats plus a
// cycle-level model of port-A arbitration and starvation.
module tb_reg_scan_arbiter;

   localparam int NUM_REGS   = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 15;
   localparam int W          = 5 + DATA_W;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              cpu_req = 1'b0;
   logic [4:0]        cpu_readRegA = '0;
   logic              cpu_stall;
   logic [4:0]        ctrl_readRegA;
   logic [DATA_W-1:0] data_readRegA;
   logic              scan_start = 1'b0;
   logic              scan_busy;
   logic              scan_done;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [4:0]        out_reg;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        state_dbg;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [W-1:0]      exp_q[$];

   int tests = 0;
   int fails = 0;
   int done_seen = 0;
   int scans_completed = 0;
   bit rand_mode = 1'b0;
   int req_pct = 0;
   int rdy_pct = 100;

   always #5 clock = ~clock;

   assign data_readRegA = regs[ctrl_readRegA];

   reg_scan_arbiter #(
      .NUM_REGS   (NUM_REGS),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .cpu_req       (cpu_req),
      .cpu_readRegA  (cpu_readRegA),
      .cpu_stall     (cpu_stall),
      .ctrl_readRegA (ctrl_readRegA),
      .data_readRegA (data_readRegA),
      .scan_start    (scan_start),
      .scan_busy     (scan_busy),
      .scan_done     (scan_done),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_reg       (out_reg),
      .out_data      (out_data),
      .state_dbg     (state_dbg)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event missing or unexpected at %0t", name, $time);
   endtask

   // Processor index always wanders; request/ready are randomized only in random phases.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         cpu_readRegA = 5'($urandom_range(0, NUM_REGS - 1));
         if (rand_mode) begin
            cpu_req   = ($urandom_range(0, 99) < req_pct);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
         end
      end
   end

   // Monitor: a scan waiting for the port is granted when the processor is idle
   // or after STARVE_MAX consecutive denials; each grant yields a beat next cycle.
   int           denied = 0;
   int           pend = 0;
   bit           done_exp = 1'b0;
   bit           waiting;
   bit           grant_exp;
   logic [W-1:0] front;
   logic [4:0]   exp_ctrl;

   always @(negedge clock) begin
      if (reset) begin
         denied   = 0;
         pend     = 0;
         done_exp = 1'b0;
      end else begin
         waiting = scan_busy && !out_valid;
         if (pend == 1) check("beat_latency", 64'(out_valid), 64'd1);
         else if (pend == 2) check("still_waiting", 64'(waiting), 64'd1);
         pend = 0;
         if (scan_done) done_seen++;
         if (scan_done || done_exp) check("scan_done", 64'(scan_done), 64'(done_exp));
         done_exp = 1'b0;
         if (waiting) begin
            grant_exp = !cpu_req || (denied == STARVE_MAX);
            check("cpu_stall", 64'(cpu_stall), 64'(cpu_req && grant_exp));
            if (exp_q.size() == 0) begin
               fail_now("scan_without_expected_beat");
            end else begin
               front    = exp_q[0];
               exp_ctrl = grant_exp ? front[DATA_W +: 5] : cpu_readRegA;
               check("ctrl_readRegA_scan", 64'(ctrl_readRegA), 64'(exp_ctrl));
            end
            if (grant_exp) begin
               denied = 0;
               pend   = 1;
            end else begin
               denied++;
               pend = 2;
            end
         end else begin
            check("cpu_stall_idle", 64'(cpu_stall), 64'd0);
            check("ctrl_readRegA_cpu", 64'(ctrl_readRegA), 64'(cpu_readRegA));
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_beat");
            end else begin
               check("beat", 64'({out_reg, out_data}), 64'(exp_q[0]));
               if (out_ready) begin
                  front = exp_q.pop_front();
                  if (front[DATA_W +: 5] == 5'(NUM_REGS - 1)) done_exp = 1'b1;
               end
            end
         end
      end
   end

   // Called at posedge+1 with the DUT idle.
   task automatic start_scan(input bit random_data);
      for (int i = 0; i < NUM_REGS; i++) regs[i] = random_data ? DATA_W'($urandom) : DATA_W'(i * 3);
      for (int i = 0; i < NUM_REGS; i++) exp_q.push_back({5'(i), regs[i]});
      scan_start = 1'b1;
      @(posedge clock);
      #1;
      scan_start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc, output int stalls);
      cyc    = 0;
      stalls = 0;
      while (!scan_done && cyc < limit) begin
         if (cpu_stall) stalls++;
         @(posedge clock);
         #1;
         cyc++;
      end
      if (!scan_done) begin
         fail_now("scan_done_timeout");
      end else begin
         scans_completed++;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic wait_beat(input int idx, input int limit);
      int n = 0;
      while (!(out_valid && out_reg == 5'(idx)) && n < limit) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (!(out_valid && out_reg == 5'(idx))) fail_now("beat_wait_timeout");
   endtask

   int cyc, stalls;
   int req_tab [4] = '{0, 50, 90, 100};
   int rdy_tab [3] = '{100, 60, 30};

   initial begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_reg", 64'(out_reg), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_scan_busy", 64'(scan_busy), 64'd0);
      check("rst_scan_done", 64'(scan_done), 64'd0);
      check("rst_cpu_stall", 64'(cpu_stall), 64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Full dump with an idle processor and an always-ready sink.
      start_scan(1'b0);
      wait_done(200, cyc, stalls);
      check("dump_cycles", 64'(cyc), 64'(2 * NUM_REGS));
      check("dump_stalls", 64'(stalls), 64'd0);

      // Processor holds the port for the whole scan: one forced beat per 16 READ cycles.
      cpu_req = 1'b1;
      start_scan(1'b1);
      wait_done(2000, cyc, stalls);
      check("starve_stalls", 64'(stalls), 64'(NUM_REGS));
      check("starve_cycles", 64'(cyc), 64'(NUM_REGS * (STARVE_MAX + 2)));
      cpu_req = 1'b0;

      // Sink back-pressure on beat 7.
      start_scan(1'b1);
      wait_beat(6, 100);
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_reg", 64'(out_reg), 64'd7);
         check("hold_data", 64'(out_data), 64'(regs[7]));
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      wait_done(300, cyc, stalls);

      // Reset in the middle of beat 10 aborts; the next scan restarts at index 0.
      start_scan(1'b1);
      wait_beat(10, 100);
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_scan_busy", 64'(scan_busy), 64'd0);
      check("abort_out_reg", 64'(out_reg), 64'd0);
      check("abort_scan_done", 64'(scan_done), 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      start_scan(1'b0);
      wait_done(200, cyc, stalls);
      check("restart_cycles", 64'(cyc), 64'(2 * NUM_REGS));

      // scan_start pulses while busy must be ignored.
      start_scan(1'b1);
      repeat (3) @(posedge clock);
      #1;
      scan_start = 1'b1;
      @(posedge clock);
      #1;
      scan_start = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      scan_start = 1'b1;
      @(posedge clock);
      #1;
      scan_start = 1'b0;
      wait_done(300, cyc, stalls);
      repeat (80) @(posedge clock);
      #1;

      // Randomized processor traffic and sink back-pressure.
      rand_mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         req_pct = req_tab[$urandom_range(0, 3)];
         rdy_pct = rdy_tab[$urandom_range(0, 2)];
         start_scan(1'b1);
         wait_done(5000, cyc, stalls);
      end
      rand_mode = 1'b0;
      cpu_req   = 1'b0;
      out_ready = 1'b1;

      repeat (20) @(posedge clock);
      #1;
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("done_pulses", 64'(done_seen), 64'(scans_completed));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
